reservation_station: RTL and testbench

//  Tomasulo reservation station directly upstream of the functional unit (FU).

---
 rtl/reservation_station.sv | 194 +++++++++++++++++++
 tb/tb_reservation_station.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station feeding a single functional unit
module reservation_station #(
    parameter int DEPTH  = 3,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [DATA_W-1:0] disp_inst,
    input  logic [TAG_W-1:0]  disp_tag,
    input  logic              disp_a_rdy,
    input  logic [DATA_W-1:0] disp_a_val,
    input  logic [TAG_W-1:0]  disp_a_tag,
    input  logic              disp_b_rdy,
    input  logic [DATA_W-1:0] disp_b_val,
    input  logic [TAG_W-1:0]  disp_b_tag,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              fu_available,
    output logic              fu_valid,
    output logic [DATA_W-1:0] fu_inst,
    output logic [TAG_W-1:0]  fu_tag,
    output logic [DATA_W-1:0] fu_r1,
    output logic [DATA_W-1:0] fu_r2
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry storage
    logic [DEPTH-1:0]  busy_q,  busy_d;
    logic [DEPTH-1:0]  a_rdy_q, a_rdy_d;
    logic [DEPTH-1:0]  b_rdy_q, b_rdy_d;
    logic [DATA_W-1:0] inst_q  [DEPTH];
    logic [DATA_W-1:0] inst_d  [DEPTH];
    logic [TAG_W-1:0]  tag_q   [DEPTH];
    logic [TAG_W-1:0]  tag_d   [DEPTH];
    logic [DATA_W-1:0] a_val_q [DEPTH];
    logic [DATA_W-1:0] a_val_d [DEPTH];
    logic [TAG_W-1:0]  a_tag_q [DEPTH];
    logic [TAG_W-1:0]  a_tag_d [DEPTH];
    logic [DATA_W-1:0] b_val_q [DEPTH];
    logic [DATA_W-1:0] b_val_d [DEPTH];
    logic [TAG_W-1:0]  b_tag_q [DEPTH];
    logic [TAG_W-1:0]  b_tag_d [DEPTH];

    // Output / status registers
    logic              rs_full_q, rs_full_d;
    logic              fu_valid_q;
    logic [DATA_W-1:0] fu_inst_q;
    logic [TAG_W-1:0]  fu_tag_q;
    logic [DATA_W-1:0] fu_r1_q;
    logic [DATA_W-1:0] fu_r2_q;

    // Selection signals
    logic [DEPTH-1:0]  ready;
    logic              any_ready;
    logic [IDX_W-1:0]  issue_idx;
    logic              issue_en;
    logic              any_free;
    logic [IDX_W-1:0]  disp_idx;
    logic              disp_en;
    logic              a_bypass;
    logic              b_bypass;

    assign rs_full  = rs_full_q;
    assign fu_valid = fu_valid_q;
    assign fu_inst  = fu_inst_q;
    assign fu_tag   = fu_tag_q;
    assign fu_r1    = fu_r1_q;
    assign fu_r2    = fu_r2_q;

    // Lowest-index ready entry and lowest-index free entry, both from registered state
    always_comb begin
        ready     = '0;
        any_ready = 1'b0;
        issue_idx = '0;
        any_free  = 1'b0;
        disp_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready[i] = busy_q[i] && a_rdy_q[i] && b_rdy_q[i];
            if (ready[i]) begin
                any_ready = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                any_free = 1'b1;
                disp_idx = IDX_W'(i);
            end
        end
    end

    // The hold-off after a pulse gives the FU a cycle to drop fu_available
    assign issue_en = fu_available && !fu_valid_q && any_ready;
    // A full station refuses dispatch even when an issue frees an entry this cycle
    assign disp_en  = disp_valid && !rs_full_q && any_free;
    assign a_bypass = cdb_valid && !disp_a_rdy && (disp_a_tag == cdb_tag);
    assign b_bypass = cdb_valid && !disp_b_rdy && (disp_b_tag == cdb_tag);

    // Next-state for every entry: CDB capture, issue release, dispatch write
    always_comb begin
        busy_d  = busy_q;
        a_rdy_d = a_rdy_q;
        b_rdy_d = b_rdy_q;
        for (int i = 0; i < DEPTH; i++) begin
            inst_d[i]  = inst_q[i];
            tag_d[i]   = tag_q[i];
            a_val_d[i] = a_val_q[i];
            a_tag_d[i] = a_tag_q[i];
            b_val_d[i] = b_val_q[i];
            b_tag_d[i] = b_tag_q[i];

            if (cdb_valid && busy_q[i] && !a_rdy_q[i] && (a_tag_q[i] == cdb_tag)) begin
                a_rdy_d[i] = 1'b1;
                a_val_d[i] = cdb_data;
            end
            if (cdb_valid && busy_q[i] && !b_rdy_q[i] && (b_tag_q[i] == cdb_tag)) begin
                b_rdy_d[i] = 1'b1;
                b_val_d[i] = cdb_data;
            end

            if (issue_en && (issue_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b0;
            end

            // Dispatch targets a free entry, so it never collides with issue or capture
            if (disp_en && (disp_idx == IDX_W'(i))) begin
                busy_d[i]  = 1'b1;
                inst_d[i]  = disp_inst;
                tag_d[i]   = disp_tag;
                a_tag_d[i] = disp_a_tag;
                b_tag_d[i] = disp_b_tag;
                a_rdy_d[i] = disp_a_rdy || a_bypass;
                b_rdy_d[i] = disp_b_rdy || b_bypass;
                a_val_d[i] = a_bypass ? cdb_data : disp_a_val;
                b_val_d[i] = b_bypass ? cdb_data : disp_b_val;
            end
        end
        rs_full_d = &busy_d;
    end

    // Entry state registers; reset drops all held work
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q    <= '0;
            a_rdy_q   <= '0;
            b_rdy_q   <= '0;
            rs_full_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]  <= '0;
                tag_q[i]   <= '0;
                a_val_q[i] <= '0;
                a_tag_q[i] <= '0;
                b_val_q[i] <= '0;
                b_tag_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            a_rdy_q   <= a_rdy_d;
            b_rdy_q   <= b_rdy_d;
            rs_full_q <= rs_full_d;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]  <= inst_d[i];
                tag_q[i]   <= tag_d[i];
                a_val_q[i] <= a_val_d[i];
                a_tag_q[i] <= a_tag_d[i];
                b_val_q[i] <= b_val_d[i];
                b_tag_q[i] <= b_tag_d[i];
            end
        end
    end

    // Issue register: one-cycle pulse, payload held between issues
    always_ff @(posedge clock) begin
        if (reset) begin
            fu_valid_q <= 1'b0;
            fu_inst_q  <= '0;
            fu_tag_q   <= '0;
            fu_r1_q    <= '0;
            fu_r2_q    <= '0;
        end else begin
            fu_valid_q <= issue_en;
            if (issue_en) begin
                fu_inst_q <= inst_q[issue_idx];
                fu_tag_q  <= tag_q[issue_idx];
                fu_r1_q   <= b_val_q[issue_idx];
                fu_r2_q   <= a_val_q[issue_idx];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
module tb_reservation_station;

    localparam int DEPTH  = 3;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_inst;
    logic [TAG_W-1:0]  disp_tag;
    logic              disp_a_rdy;
    logic [DATA_W-1:0] disp_a_val;
    logic [TAG_W-1:0]  disp_a_tag;
    logic              disp_b_rdy;
    logic [DATA_W-1:0] disp_b_val;
    logic [TAG_W-1:0]  disp_b_tag;
    logic              rs_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              fu_available;
    logic              fu_valid;
    logic [DATA_W-1:0] fu_inst;
    logic [TAG_W-1:0]  fu_tag;
    logic [DATA_W-1:0] fu_r1;
    logic [DATA_W-1:0] fu_r2;

    typedef struct {
        logic [DATA_W-1:0] inst;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
    } issue_t;

    issue_t exp_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    logic   prev_fv  = 1'b0;

    reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .disp_valid   (disp_valid),
        .disp_inst    (disp_inst),
        .disp_tag     (disp_tag),
        .disp_a_rdy   (disp_a_rdy),
        .disp_a_val   (disp_a_val),
        .disp_a_tag   (disp_a_tag),
        .disp_b_rdy   (disp_b_rdy),
        .disp_b_val   (disp_b_val),
        .disp_b_tag   (disp_b_tag),
        .rs_full      (rs_full),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .fu_available (fu_available),
        .fu_valid     (fu_valid),
        .fu_inst      (fu_inst),
        .fu_tag       (fu_tag),
        .fu_r1        (fu_r1),
        .fu_r2        (fu_r2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard: every issue pulse is matched against the oldest expectation
    always @(negedge clock) begin
        if (fu_valid === 1'b1) begin
            if (prev_fv) check("holdoff_violation", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {48'd0, fu_inst}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                issue_t e;
                e = exp_q.pop_front();
                check("fu_inst", fu_inst, e.inst);
                check("fu_tag",  fu_tag,  e.tag);
                check("fu_r1",   fu_r1,   e.r1);
                check("fu_r2",   fu_r2,   e.r2);
            end
        end
        prev_fv = (fu_valid === 1'b1);
    end

    task automatic expect_issue(input logic [DATA_W-1:0] inst, input logic [TAG_W-1:0] tag,
                                input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2);
        issue_t e;
        e.inst = inst; e.tag = tag; e.r1 = r1; e.r2 = r2;
        exp_q.push_back(e);
    endtask

    task automatic drive_disp(input logic [DATA_W-1:0] inst, input logic [TAG_W-1:0] tag,
                              input logic ardy, input logic [DATA_W-1:0] aval, input logic [TAG_W-1:0] atag,
                              input logic brdy, input logic [DATA_W-1:0] bval, input logic [TAG_W-1:0] btag);
        disp_valid = 1'b1; disp_inst = inst; disp_tag = tag;
        disp_a_rdy = ardy; disp_a_val = aval; disp_a_tag = atag;
        disp_b_rdy = brdy; disp_b_val = bval; disp_b_tag = btag;
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0; cdb_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clock);
        @(negedge clock);
        check(tag, exp_q.size(), 0);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fu_available = 1'b0;
        disp_valid = 1'b0; disp_inst = '0; disp_tag = '0;
        disp_a_rdy = 1'b0; disp_a_val = '0; disp_a_tag = '0;
        disp_b_rdy = 1'b0; disp_b_val = '0; disp_b_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        repeat (2) @(negedge clock);
        check("reset_rs_full", rs_full, 0);
        check("reset_fu_valid", fu_valid, 0);
        check("reset_fu_payload", {fu_inst, fu_tag, fu_r1, fu_r2}, 0);
        reset = 1'b0;

        // 1: ready add issues the edge after it is written
        fu_available = 1'b1;
        expect_issue(16'h0000, 3'd1, 16'd3, 16'd5);
        drive_disp(16'h0000, 3'd1, 1'b1, 16'd5, 3'd0, 1'b1, 16'd3, 3'd0);
        @(negedge clock);
        idle_inputs();
        check("t1_not_yet", fu_valid, 0);
        check("t1_rs_full", rs_full, 0);
        @(negedge clock);
        check("t1_issue", fu_valid, 1);
        wait_drain("t1_drain");

        // 2: A waits on tag 5, captured from the CDB two cycles later
        expect_issue(16'h0001, 3'd2, 16'd4, 16'd10);
        drive_disp(16'h0001, 3'd2, 1'b0, 16'd0, 3'd5, 1'b1, 16'd4, 3'd0);
        @(negedge clock);
        idle_inputs();
        check("t2_wait0", fu_valid, 0);
        @(negedge clock);
        check("t2_wait1", fu_valid, 0);
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'd10;
        @(negedge clock);
        cdb_valid = 1'b0;
        check("t2_capture_edge", fu_valid, 0);
        @(negedge clock);
        check("t2_issue", fu_valid, 1);
        wait_drain("t2_drain");

        // 3: both operands bypassed from the CDB during dispatch
        expect_issue(16'h0004, 3'd3, 16'd7, 16'd7);
        drive_disp(16'h0004, 3'd3, 1'b0, 16'd0, 3'd6, 1'b0, 16'd0, 3'd6);
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'd7;
        @(negedge clock);
        idle_inputs();
        check("t3_not_yet", fu_valid, 0);
        @(negedge clock);
        check("t3_issue", fu_valid, 1);
        wait_drain("t3_drain");

        // 4: fill, overflow dispatch ignored, then drain on alternate cycles
        fu_available = 1'b0;
        expect_issue(16'h0000, 3'd1, 16'd12, 16'd11);
        expect_issue(16'h0001, 3'd2, 16'd22, 16'd21);
        expect_issue(16'h00F7, 3'd3, 16'd32, 16'd31);
        drive_disp(16'h0000, 3'd1, 1'b1, 16'd11, 3'd0, 1'b1, 16'd12, 3'd0);
        @(negedge clock);
        check("t4_rs_full_1", rs_full, 0);
        drive_disp(16'h0001, 3'd2, 1'b1, 16'd21, 3'd0, 1'b1, 16'd22, 3'd0);
        @(negedge clock);
        check("t4_rs_full_2", rs_full, 0);
        drive_disp(16'h00F7, 3'd3, 1'b1, 16'd31, 3'd0, 1'b1, 16'd32, 3'd0);
        @(negedge clock);
        check("t4_rs_full_3", rs_full, 1);
        drive_disp(16'h0004, 3'd4, 1'b1, 16'd41, 3'd0, 1'b1, 16'd42, 3'd0);
        @(negedge clock);
        check("t4_still_full", rs_full, 1);
        idle_inputs();
        fu_available = 1'b1;
        @(negedge clock);
        check("t4_first_issue", fu_valid, 1);
        check("t4_full_drops", rs_full, 0);
        @(negedge clock);
        check("t4_gap", fu_valid, 0);
        @(negedge clock);
        check("t4_second_issue", fu_valid, 1);
        wait_drain("t4_drain");

        // 5: entry 1 overtakes a waiting entry 0; no back-to-back issue
        fu_available = 1'b0;
        expect_issue(16'h0000, 3'd1, 16'd21, 16'd20);
        expect_issue(16'h0001, 3'd2, 16'd31, 16'd30);
        drive_disp(16'h0100, 3'd5, 1'b0, 16'd0, 3'd6, 1'b1, 16'd9, 3'd0);
        @(negedge clock);
        drive_disp(16'h0000, 3'd1, 1'b1, 16'd20, 3'd0, 1'b1, 16'd21, 3'd0);
        @(negedge clock);
        drive_disp(16'h0001, 3'd2, 1'b1, 16'd30, 3'd0, 1'b1, 16'd31, 3'd0);
        @(negedge clock);
        idle_inputs();
        fu_available = 1'b1;
        @(negedge clock);
        check("t5_first", fu_valid, 1);
        @(negedge clock);
        check("t5_blocked", fu_valid, 0);
        wait_drain("t5_drain_a");
        expect_issue(16'h0100, 3'd5, 16'd9, 16'h0055);
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h0055;
        @(negedge clock);
        cdb_valid = 1'b0;
        wait_drain("t5_drain_b");

        // 6: reset with busy entries and a live issue pulse
        fu_available = 1'b0;
        expect_issue(16'h0000, 3'd1, 16'd2, 16'd1);
        drive_disp(16'h0000, 3'd1, 1'b1, 16'd1, 3'd0, 1'b1, 16'd2, 3'd0);
        @(negedge clock);
        drive_disp(16'h0001, 3'd2, 1'b0, 16'd0, 3'd5, 1'b1, 16'd3, 3'd0);
        @(negedge clock);
        drive_disp(16'h0004, 3'd3, 1'b1, 16'd4, 3'd0, 1'b0, 16'd0, 3'd5);
        @(negedge clock);
        idle_inputs();
        fu_available = 1'b1;
        @(negedge clock);
        check("t6_pulse_before_reset", fu_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_fu_valid", fu_valid, 0);
        check("t6_rs_full", rs_full, 0);
        check("t6_payload", {fu_inst, fu_tag, fu_r1, fu_r2}, 0);
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h0077;
        @(negedge clock);
        cdb_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("t6_no_issue", fu_valid, 0);
        end
        check("t6_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
